fetch_line_buffer: RTL

Instruction fetch front end that sits directly upstream of the x86-64 decoder in the core.
- Issues 64-byte cache-line read requests on the system bus.
- Accepts 8-byte response beats into a circular byte buffer.
- Presents a 15-byte, RIP-tagged window to the decoder, which returns a per-cycle consume count.
- Supports entry at an unaligned address and a redirect (flush and refetch) from downstream.

---
 rtl/fetch_line_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_line_buffer.sv
// Fetch front end: requests 64B lines, packs 8B beats into a circular buffer, and shows a 15B RIP-tagged window.
// Beats and consumes are visible the cycle after their edge; requests are throttled by occupancy, and beats are always acked.
module fetch_line_buffer #(
    parameter int BUF_BYTES     = 128,
    parameter int WINDOW        = 15,
    parameter int REFILL_THRESH = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [63:0]         i_entry,
    input  logic                i_redirect,
    input  logic [63:0]         i_redirect_rip,
    output logic                o_reqcyc,
    output logic [63:0]         o_req,
    input  logic                i_reqack,
    input  logic                i_respcyc,
    input  logic [63:0]         i_resp,
    output logic                o_respack,
    output logic [8*WINDOW-1:0] o_window,
    output logic [63:0]         o_window_rip,
    output logic                o_window_valid,
    input  logic [3:0]          i_consume
);
    localparam int AW = $clog2(BUF_BYTES);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAITING, ACTIVE} state_t;
    state_t r_state, w_state_nxt;

    logic [7:0]    r_buf [BUF_BYTES];
    logic [PW-1:0] r_rd, r_wr;
    logic [63:0]   r_fetch, r_req, r_rip;
    logic [2:0]    r_skip, r_off, r_beat_cnt;
    logic          r_prime, r_discard, r_reqcyc;

    logic [PW-1:0] w_occ;
    logic          w_valid, w_beat, w_last_beat, w_keep, w_consume, w_issue;

    assign w_occ          = r_wr - r_rd;
    assign w_valid        = (w_occ >= PW'(WINDOW));
    assign o_window_valid = w_valid;
    assign o_window_rip   = r_rip;
    assign o_reqcyc       = r_reqcyc;
    assign o_req          = r_req;
    assign o_respack      = i_respcyc;

    always_comb begin
        w_state_nxt = r_state;
        w_beat      = i_respcyc && (r_state != IDLE);
        w_last_beat = w_beat && (r_beat_cnt == 3'd7);
        // Redirect wins over a same-cycle beat write and consume.
        w_keep      = w_beat && !r_discard && (r_skip == 3'd0) && !i_redirect;
        w_consume   = w_valid && !i_redirect;
        w_issue     = (r_state == IDLE) && !r_reqcyc && !i_reqack && !i_redirect
                      && (w_occ < PW'(REFILL_THRESH));
        case (r_state)
            IDLE:    if (i_reqack) w_state_nxt = WAITING;
            WAITING: if (i_respcyc) w_state_nxt = ACTIVE;
            ACTIVE:  if (w_last_beat) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_reqcyc   <= 1'b0;
            r_req      <= {i_entry[63:6], 6'b0};
            r_fetch    <= {i_entry[63:6], 6'b0};
            r_rd       <= '0;
            r_wr       <= '0;
            r_rip      <= i_entry;
            r_skip     <= i_entry[5:3];
            r_off      <= i_entry[2:0];
            r_prime    <= 1'b1;
            r_discard  <= 1'b0;
            r_beat_cnt <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_reqcyc <= 1'b1;
                r_req    <= r_fetch;
            end else if (i_reqack) begin
                r_reqcyc <= 1'b0;
            end
            if (w_beat) r_beat_cnt <= r_beat_cnt + 3'd1;
            if (w_last_beat) begin
                r_discard <= 1'b0;
                if (!r_discard) r_fetch <= r_fetch + 64'd64;
            end
            if (w_beat && !r_discard && (r_skip != 3'd0)) r_skip <= r_skip - 3'd1;
            if (w_keep) begin
                r_wr    <= r_wr + PW'(8);
                r_prime <= 1'b0;
            end
            // The first kept beat of a fresh stream places rd at the entry byte offset.
            if (w_keep && r_prime) begin
                r_rd <= r_wr + PW'(r_off);
            end else if (w_consume) begin
                r_rd  <= r_rd + PW'(i_consume);
                r_rip <= r_rip + 64'(i_consume);
            end
            if (i_redirect) begin
                r_rd      <= '0;
                r_wr      <= '0;
                r_rip     <= i_redirect_rip;
                r_fetch   <= {i_redirect_rip[63:6], 6'b0};
                r_skip    <= i_redirect_rip[5:3];
                r_off     <= i_redirect_rip[2:0];
                r_prime   <= 1'b1;
                // An in-flight or still-pending line is stale and must drain unwritten.
                r_discard <= (r_state == IDLE) ? r_reqcyc : !w_last_beat;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_keep && !i_reset) begin
            for (int i = 0; i < 8; i++) begin
                r_buf[r_wr[AW-1:0] + AW'(i)] <= i_resp[8*i +: 8];
            end
        end
    end

    always_comb begin
        o_window = '0;
        for (int i = 0; i < WINDOW; i++) begin
            o_window[8*i +: 8] = r_buf[r_rd[AW-1:0] + AW'(i)];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(i_reqack && (r_state != IDLE)));
            assert (!(i_respcyc && (r_state == IDLE)));
            assert (!(w_consume && (PW'(i_consume) > w_occ)));
        end
    end
endmodule
